// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues a handshaked read for the PC word index and holds the returned word.
// The jump/branch fields are predecoded from the held word and masked while no valid instruction is held.
module instr_fetch #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        jump,
    output logic        branch,
    output logic [25:0] jump_addr,
    output logic [15:0] branch_off,
    output logic        fetch_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    // Last REQ cycle that may still see an ack before the fetch is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [29:0] pc_q;
    logic [7:0]  cnt_q;
    logic [31:0] instr_q;
    logic        mem_req_q;
    logic        instr_valid_q;
    logic        fetch_err_q;

    // The top two index bits fall off the end when forming a byte address.
    logic        pc_hi_unused;
    assign pc_hi_unused = ^pc[31:30];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            instr_q       <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pc_valid) begin
                        pc_q      <= pc[29:0];
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack wins over a simultaneous timeout.
                    if (mem_ack) begin
                        instr_q       <= mem_rdata;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (pc_valid) begin
                            pc_q      <= pc[29:0];
                            cnt_q     <= '0;
                            mem_req_q <= 1'b1;
                            state_q   <= S_REQ;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = {pc_q, 2'b00};
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = (state_q != S_IDLE);

    assign jump       = instr_valid_q & ((instr_q[31:26] == 6'b000010) | (instr_q[31:26] == 6'b000011));
    assign branch     = instr_valid_q & (instr_q[31:26] == 6'b000100);
    assign jump_addr  = instr_valid_q ? instr_q[25:0] : 26'd0;
    assign branch_off = instr_valid_q ? instr_q[15:0] : 16'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized fetches checked against
// a per-transaction model (ack delay vs timeout decides success or error).
module tb_instr_fetch;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        jump;
    logic        branch;
    logic [25:0] jump_addr;
    logic [15:0] branch_off;
    logic        fetch_err;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_instr;

    instr_fetch #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .jump        (jump),
        .branch      (branch),
        .jump_addr   (jump_addr),
        .branch_off  (branch_off),
        .fetch_err   (fetch_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_jump(input logic [31:0] d);
        return (d[31:26] == 6'd2) || (d[31:26] == 6'd3);
    endfunction

    function automatic logic is_branch(input logic [31:0] d);
        return d[31:26] == 6'd4;
    endfunction

    function automatic logic [31:0] make_instr();
        logic [31:0] r;
        logic [5:0]  op;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: op = 6'd2;
            1: op = 6'd3;
            2: op = 6'd4;
            default: op = r[31:26];
        endcase
        return {op, r[25:0]};
    endfunction

    task automatic chk_hold(input logic [31:0] d);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", instr, d);
        chk("hold_jump", 32'(jump), 32'(is_jump(d)));
        chk("hold_branch", 32'(branch), 32'(is_branch(d)));
        chk("hold_jump_addr", 32'(jump_addr), 32'(d[25:0]));
        chk("hold_branch_off", 32'(branch_off), 32'(d[15:0]));
        chk("hold_mem_req", 32'(mem_req), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_jump"}, 32'(jump), 32'd0);
        chk({tag, "_branch"}, 32'(branch), 32'd0);
        chk({tag, "_jump_addr"}, 32'(jump_addr), 32'd0);
        chk({tag, "_branch_off"}, 32'(branch_off), 32'd0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One fetch: ack arrives in REQ cycle dly (0-based); dly >= TO means no ack ever.
    task automatic do_fetch(input logic [31:0] p, input bit issued, input int dly,
                            input logic [31:0] d, input int rwait, input bit chain,
                            input logic [31:0] np);
        logic [31:0] addr;
        addr = p << 2;
        $display("[TB] fetch pc=0x%08h dly=%0d data=0x%08h rwait=%0d chain=%0d",
                 p, dly, d, rwait, chain);
        if (!issued) begin
            pc       = p;
            pc_valid = 1'b1;
            step();
            pc_valid = 1'b0;
        end
        for (int k = 0; k < TO; k++) begin
            chk("req_mem_req", 32'(mem_req), 32'd1);
            chk("req_addr", mem_addr, addr);
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_valid", 32'(instr_valid), 32'd0);
            pc_valid  = 1'($urandom_range(0, 1));
            pc        = $urandom;
            mem_ack   = (k == dly);
            mem_rdata = (k == dly) ? d : $urandom;
            step();
            mem_ack  = 1'b0;
            pc_valid = 1'b0;
            if (k == dly) break;
        end
        if (dly < TO) begin
            last_instr = d;
            chk("ack_fetch_err", 32'(fetch_err), 32'd0);
            for (int w = 0; w < rwait; w++) begin
                chk_hold(d);
                pc_valid = 1'($urandom_range(0, 1));
                pc       = $urandom;
                step();
                pc_valid = 1'b0;
            end
            chk_hold(d);
            instr_ready = 1'b1;
            pc_valid    = chain;
            pc          = np;
            step();
            instr_ready = 1'b0;
            pc_valid    = 1'b0;
            chk("post_valid", 32'(instr_valid), 32'd0);
            chk("post_jump", 32'(jump), 32'd0);
            chk("post_mem_req", 32'(mem_req), 32'(chain));
            chk("post_busy", 32'(busy), 32'(chain));
            if (chain) chk("chain_addr", mem_addr, np << 2);
        end else begin
            chk("err_pulse", 32'(fetch_err), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_mem_req", 32'(mem_req), 32'd0);
            chk("err_valid", 32'(instr_valid), 32'd0);
            chk("err_instr", instr, last_instr);
            step();
            chk("err_clear", 32'(fetch_err), 32'd0);
        end
    endtask

    initial begin
        bit          pend;
        logic [31:0] ppc;
        logic [31:0] np;
        int          dly;
        bit          ch;

        rst_n       = 1'b0;
        pc          = '0;
        pc_valid    = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        last_instr  = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk_reset_outputs("reset");

        // Jump decode with zero-wait memory.
        do_fetch(32'h5, 1'b0, 0, 32'h0800_0123, 0, 1'b0, '0);
        // Branch decode, ack in the last allowed REQ cycle, held by backpressure.
        do_fetch(32'h10, 1'b0, 3, 32'h1043_FFFC, 4, 1'b0, '0);
        // Timeout: no ack at all.
        do_fetch(32'h7, 1'b0, TO, 32'h0, 0, 1'b0, '0);
        // Handshake with a new index in the same cycle goes straight back to REQ.
        do_fetch(32'h40, 1'b0, 1, 32'h0C00_0042, 1, 1'b1, 32'h21);
        do_fetch(32'h21, 1'b1, 0, 32'hDEAD_BEEF, 0, 1'b0, '0);

        pend = 1'b0;
        ppc  = '0;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] p;
            p   = pend ? ppc : $urandom;
            dly = $urandom_range(0, TO + 1);
            ch  = (dly < TO) && ($urandom_range(0, 1) == 1);
            np  = $urandom;
            do_fetch(p, pend, dly, make_instr(), $urandom_range(0, 3), ch, np);
            pend = ch;
            ppc  = np;
        end
        if (pend) do_fetch(ppc, 1'b1, 0, make_instr(), 0, 1'b0, '0);

        // Reset in the middle of a request; a late ack must be ignored.
        $display("[TB] reset mid-fetch");
        pc       = 32'h33;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0800_FFFF;
        step();
        step();
        mem_ack = 1'b0;
        chk_reset_outputs("late_ack");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch-and-predecode stage paired with the program-counter block. It takes the word index the PC produces, issues a handshaked read to instruction memory, and holds the returned instruction for the datapath. It also decodes the `jump`, `branch`, `jump_addr` and `branch_off` fields that the PC block consumes to form the next index. Memory latency is variable and bounded by a timeout.

## Interface
- `TIMEOUT`, 15: maximum `mem_req` cycles without `mem_ack` before abort; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `pc`  in  32  word index from PC block.
- `pc_valid`  in  1  `pc` holds a new index to fetch.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  byte address, `{pc_q[29:0], 2'b00}`.
- `mem_ack`  in  1  `mem_rdata` valid this cycle; meaningful only while `mem_req`=1.
- `mem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` and decode outputs valid.
- `instr_ready`  in  1  downstream accepts `instr`.
- `instr`  out  32  held instruction.
- `jump`  out  1  opcode `instr[31:26]` is 6'b000010 or 6'b000011; gated by `instr_valid`.
- `branch`  out  1  opcode is 6'b000100; gated by `instr_valid`.
- `jump_addr`  out  26  `instr[25:0]` while `instr_valid`, else 0.
- `branch_off`  out  16  `instr[15:0]` while `instr_valid`, else 0.
- `fetch_err`  out  1  one-cycle pulse on timeout.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, REQ, HOLD.
- IDLE:
  - When `pc_valid`=1, register `pc` into `pc_q`, clear the wait counter, and go to REQ.
  - `mem_ack` is ignored.
- REQ:
  - `mem_req`=1 and `mem_addr` is driven from `pc_q`.
  - When `mem_ack`=1, capture `mem_rdata` into `instr` and go to HOLD.
  - Otherwise the wait counter (8 bit) increments.
  - If no ack arrives and the counter reaches `TIMEOUT`-1, pulse `fetch_err` for one cycle, leave `instr` unchanged, and go to IDLE.
  - An ack that arrives in the same cycle as the timeout condition takes precedence: no error, go to HOLD.
- HOLD:
  - `instr_valid`=1. `instr` and the decode outputs are stable until the handshake.
  - On `instr_valid & instr_ready`:
    - if `pc_valid`=1 the same cycle, latch `pc` and go directly to REQ;
    - otherwise go to IDLE.
- `pc_valid` is ignored in REQ, and in HOLD without `instr_ready`. The PC block must hold the value until `busy`=0 or the handshake cycle.
- Decode is combinational from the `instr` register and masked by `instr_valid`. Unrecognised opcodes give `jump`=`branch`=0, with fields still passed through.
- Address is word index × 4; the upper two `pc` bits are discarded.

## Timing
- Reset (async assert, sync release):
  - state=IDLE;
  - `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_valid`=0;
  - `jump`=`branch`=0, `jump_addr`=0, `branch_off`=0;
  - `fetch_err`=0, `busy`=0;
  - counter=0, `pc_q`=0.
- Reset mid-fetch drops `mem_req` immediately, and any late `mem_ack` is ignored.
- `pc_valid` sampled at edge N → `mem_req`=1 from cycle N+1.
- `mem_ack` sampled at edge M → `instr_valid`=1 from cycle M+1. Minimum latency from `pc_valid` to `instr_valid` is 2 cycles.
- Back-to-back with zero-wait memory: one instruction every 2 cycles.
- `mem_req` is a registered output; `mem_addr` is constant while `mem_req`=1.
- `fetch_err` is high exactly in the cycle after the last unacknowledged REQ cycle. `busy` is 0 in that cycle.

## Test plan
- Reset, then `pc`=0x5, `pc_valid`=1, immediate `mem_ack` with `mem_rdata`=0x08000123 → `mem_addr`=0x14. Next cycle `instr_valid`=1, `jump`=1, `branch`=0, `jump_addr`=0x0000123.
- `pc`=0x10, ack after 3 wait cycles with data 0x1043FFFC, `instr_ready` held 0 for 4 cycles → `branch`=1 and `branch_off`=0xFFFC, stable throughout. Return to IDLE after `instr_ready`=1.
- `TIMEOUT`=4, no `mem_ack` → `mem_req` high for exactly 4 cycles, one `fetch_err` pulse, `instr_valid` stays 0.
- `TIMEOUT`=4, ack in the 4th REQ cycle → no `fetch_err`, `instr_valid` rises.
- Handshake cycle with `pc_valid`=1, `pc`=0x21 → `mem_req` the next cycle with `mem_addr`=0x84, and `instr_valid` low.
- Assert `rst_n`=0 mid-REQ, then apply `mem_ack` after release → all outputs at reset values, ack ignored.
